wb_cpu_bus_decoder: RTL and testbench
=====================================

Name: wb_cpu_bus_decoder

Overview:
Wishbone bus decoder and watchdog directly downstream of the Z80 Wishbone master. It takes the single CPU master port and routes each cycle by tag to either the memory slave port (tag 2'b00) or the I/O slave port (tag 2'b01). All outputs to both sides are registered, and unacknowledged cycles end with a timeout so the CPU can never hang. It also returns the floating-bus value for unmapped tags and for timed-out reads.

Parameters:
TIMEOUT_CYCLES, 16, number of cycles spent in MEM/IO without slave ack before forced termination (legal range 2..255)
FLOAT_DATA, 8'hFF, read data returned on timeout or unmapped tag

Ports:
clk_i  in  1  clock
nrst_i  in  1  reset, asynchronous, active-low
s_adr_i  in  16  CPU master address
s_tga_i  in  2  CPU master tag: 00 mem, 01 io, 10/11 unmapped
s_dat_i  in  8  CPU write data
s_dat_o  out  8  read data to CPU
s_cyc_i  in  1  master cycle
s_stb_i  in  1  master strobe
s_we_i  in  1  master write enable
s_ack_o  out  1  ack to CPU, one-cycle pulse
mem_adr_o  out  16  memory slave address
mem_dat_o  out  8  memory slave write data
mem_dat_i  in  8  memory slave read data
mem_cyc_o / mem_stb_o / mem_we_o  out  1 each  memory slave control
mem_ack_i  in  1  memory slave ack
io_adr_o / io_dat_o / io_dat_i / io_cyc_o / io_stb_o / io_we_o / io_ack_i  same as mem_*, for the I/O slave
tmo_o  out  1  one-cycle pulse on timeout
tmo_cnt_o  out  8  saturating timeout counter

Behaviour:
- Reset (async, nrst_i=0): state=IDLE. All outputs are 0: s_dat_o, s_ack_o, all mem_*/io_* outputs, tmo_o, tmo_cnt_o. Internal latches and the wait counter are also 0.
- States: IDLE, MEM, IO, DONE, RELEASE.
- IDLE, on s_cyc_i&s_stb_i sampled high:
  - Latch adr, dat, and we.
  - tga=00: go to MEM; assert mem_cyc_o=mem_stb_o=1 and mem_we_o=latched we from the next cycle.
  - tga=01: go to IO; assert the io_* equivalents.
  - tga=10/11: go to DONE with rdata=FLOAT_DATA. No slave access; no timeout counted.
- mem_adr_o/mem_dat_o and io_adr_o/io_dat_o are driven from the latched values. They hold stable for the whole slave cycle. The inactive port's cyc/stb/we stay 0; at most one port is active at any time.
- MEM/IO: the wait counter clears on entry and increments every cycle without ack.
  - Slave ack sampled high: capture slave dat_i into rdata (write cycles capture it too; the value is don't-care to the CPU). Drop slave cyc/stb/we at the same edge. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: drop slave cyc/stb/we, set rdata=FLOAT_DATA, pulse tmo_o for one cycle, increment tmo_cnt_o (saturates at 255), go to DONE.
  - Ack and the timeout condition in the same cycle: ack wins; no tmo_o, no count.
  - Master abort (s_cyc_i sampled low): drop slave cyc/stb/we, go to IDLE. No s_ack_o, no tmo_o.
- DONE: s_ack_o=1 for exactly one cycle. s_dat_o=rdata, and s_dat_o holds that value until the next DONE. Go to RELEASE.
- RELEASE: wait until s_stb_i is sampled low, then go to IDLE. A new request is never accepted in the same cycle as s_ack_o, nor while the strobe from the previous cycle is still high.
- Latency, zero-wait slave (ack combinational on stb):
  - edge0: request sampled.
  - cycle1: slave stb=1.
  - edge2: ack sampled.
  - cycle3: s_ack_o=1.
  - CPU request to ack is 3 cycles. Each slave wait state adds 1 cycle.
- A late slave ack arriving after a timeout or abort is ignored, because the slave stb is already low.
- Async reset mid-cycle: all outputs go to 0 immediately and the FSM returns to IDLE.

Test Plan:
- Mem read: adr=16'h4000, tga=00, we=0; mem slave acks on the first stb cycle with 8'hA5 -> mem_adr_o=4000 and mem_stb_o high for exactly 1 cycle; s_ack_o pulses 3 cycles after the request with s_dat_o=A5; io_* stay 0.
- IO write with waits: adr=16'h7F10, tga=01, we=1, dat=8'h8C; io slave acks after 3 wait cycles -> io_adr_o=7F10, io_dat_o=8C, io_we_o=1 held for 4 cycles; s_ack_o pulses once; mem_* stay 0.
- Timeout: mem read, slave never acks, TIMEOUT_CYCLES=16 -> mem_stb_o drops after 16 cycles; tmo_o pulses once; tmo_cnt_o goes 0->1; s_ack_o pulses with s_dat_o=FF. A later spurious mem_ack_i has no effect.
- Unmapped tag: tga=10, read -> no slave strobes; s_ack_o pulses 2 cycles after the request with s_dat_o=FF; tmo_o=0.
- Corner case, ack on the last timeout cycle: slave acks exactly on cycle 16 with 8'h3C -> s_dat_o=3C, tmo_o=0, tmo_cnt_o unchanged.
- Abort and reset: master drops cyc at wait cycle 2 -> slave stb drops at the next edge and no s_ack_o. Then assert nrst_i low mid-IO-cycle -> all outputs are 0 asynchronously; after release, a fresh mem read completes normally.

Source files
------------

// File: rtl/wb_cpu_bus_decoder.sv
// Wishbone decoder between the Z80 master and its memory / I/O slaves.
// Routes each master cycle by tag, registers every slave-side and master-side
// output, and forces a floating-bus termination when a slave never answers.
//
// Handshake: a master request is taken when s_cyc_i & s_stb_i are sampled
// high in IDLE. The selected slave sees cyc=stb=1 from the following cycle
// until the edge where its ack is sampled high (or timeout / abort). The
// master then sees s_ack_o for exactly one cycle, with s_dat_o valid in
// that cycle, and must drop s_stb_i before another request is accepted.
module wb_cpu_bus_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  FLOAT_DATA     = 8'hFF
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  // CPU master port
  input  logic [15:0] s_adr_i,
  input  logic [1:0]  s_tga_i,
  input  logic [7:0]  s_dat_i,
  output logic [7:0]  s_dat_o,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  output logic        s_ack_o,
  // memory slave port
  output logic [15:0] mem_adr_o,
  output logic [7:0]  mem_dat_o,
  input  logic [7:0]  mem_dat_i,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  input  logic        mem_ack_i,
  // I/O slave port
  output logic [15:0] io_adr_o,
  output logic [7:0]  io_dat_o,
  input  logic [7:0]  io_dat_i,
  output logic        io_cyc_o,
  output logic        io_stb_o,
  output logic        io_we_o,
  input  logic        io_ack_i,
  // watchdog status
  output logic        tmo_o,
  output logic [7:0]  tmo_cnt_o
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEM     = 3'd1,
    ST_IO      = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mem_adr_q, mem_adr_d;
  logic [7:0]  mem_dat_q, mem_dat_d;
  logic        mem_act_q, mem_act_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] io_adr_q, io_adr_d;
  logic [7:0]  io_dat_q, io_dat_d;
  logic        io_act_q, io_act_d;
  logic        io_we_q, io_we_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  s_dat_q, s_dat_d;
  logic        s_ack_q, s_ack_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  wait_q, wait_d;

  // Ack/data of whichever slave the current cycle targets.
  logic        slv_ack;
  logic [7:0]  slv_dat;
  assign slv_ack = (state_q == ST_MEM) ? mem_ack_i : io_ack_i;
  assign slv_dat = (state_q == ST_MEM) ? mem_dat_i : io_dat_i;

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= ST_IDLE;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      mem_act_q <= 1'b0;
      mem_we_q  <= 1'b0;
      io_adr_q  <= '0;
      io_dat_q  <= '0;
      io_act_q  <= 1'b0;
      io_we_q   <= 1'b0;
      rdata_q   <= '0;
      s_dat_q   <= '0;
      s_ack_q   <= 1'b0;
      tmo_q     <= 1'b0;
      tmo_cnt_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
      mem_act_q <= mem_act_d;
      mem_we_q  <= mem_we_d;
      io_adr_q  <= io_adr_d;
      io_dat_q  <= io_dat_d;
      io_act_q  <= io_act_d;
      io_we_q   <= io_we_d;
      rdata_q   <= rdata_d;
      s_dat_q   <= s_dat_d;
      s_ack_q   <= s_ack_d;
      tmo_q     <= tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    mem_adr_d = mem_adr_q;
    mem_dat_d = mem_dat_q;
    mem_act_d = mem_act_q;
    mem_we_d  = mem_we_q;
    io_adr_d  = io_adr_q;
    io_dat_d  = io_dat_q;
    io_act_d  = io_act_q;
    io_we_d   = io_we_q;
    rdata_d   = rdata_q;
    s_dat_d   = s_dat_q;
    s_ack_d   = 1'b0;
    tmo_d     = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
    wait_d    = wait_q;

    case (state_q)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          case (s_tga_i)
            2'b00: begin
              mem_adr_d = s_adr_i;
              mem_dat_d = s_dat_i;
              mem_we_d  = s_we_i;
              mem_act_d = 1'b1;
              wait_d    = '0;
              state_d   = ST_MEM;
            end
            2'b01: begin
              io_adr_d = s_adr_i;
              io_dat_d = s_dat_i;
              io_we_d  = s_we_i;
              io_act_d = 1'b1;
              wait_d   = '0;
              state_d  = ST_IO;
            end
            default: begin
              // Unmapped tag: answer with the floating bus, no slave access.
              rdata_d = FLOAT_DATA;
              state_d = ST_DONE;
            end
          endcase
        end
      end

      ST_MEM, ST_IO: begin
        if (!s_cyc_i) begin
          // Master abandoned the cycle: release the slave, no reply.
          mem_act_d = 1'b0;
          mem_we_d  = 1'b0;
          io_act_d  = 1'b0;
          io_we_d   = 1'b0;
          state_d   = ST_IDLE;
        end else if (slv_ack) begin
          // Ack has priority over a timeout on the same edge.
          rdata_d   = slv_dat;
          mem_act_d = 1'b0;
          mem_we_d  = 1'b0;
          io_act_d  = 1'b0;
          io_we_d   = 1'b0;
          state_d   = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          rdata_d   = FLOAT_DATA;
          mem_act_d = 1'b0;
          mem_we_d  = 1'b0;
          io_act_d  = 1'b0;
          io_we_d   = 1'b0;
          tmo_d     = 1'b1;
          if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
          state_d   = ST_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_DONE: begin
        s_ack_d = 1'b1;
        s_dat_d = rdata_q;
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // Hold off until the master has dropped the strobe of the old cycle.
        if (!s_stb_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_dat_o   = s_dat_q;
  assign s_ack_o   = s_ack_q;
  assign mem_adr_o = mem_adr_q;
  assign mem_dat_o = mem_dat_q;
  assign mem_cyc_o = mem_act_q;
  assign mem_stb_o = mem_act_q;
  assign mem_we_o  = mem_we_q;
  assign io_adr_o  = io_adr_q;
  assign io_dat_o  = io_dat_q;
  assign io_cyc_o  = io_act_q;
  assign io_stb_o  = io_act_q;
  assign io_we_o   = io_we_q;
  assign tmo_o     = tmo_q;
  assign tmo_cnt_o = tmo_cnt_q;

endmodule

// File: tb/tb_wb_cpu_bus_decoder.sv
// Bench for wb_cpu_bus_decoder: directed scenarios plus random transactions
// against a transaction-level model of latency, data and watchdog counting.
module tb_wb_cpu_bus_decoder;

  localparam int         TMO   = 16;
  localparam logic [7:0] FLOAT = 8'hFF;
  localparam int         NEVER = 1000;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic [15:0] s_adr_i;
  logic [1:0]  s_tga_i;
  logic [7:0]  s_dat_i;
  logic [7:0]  s_dat_o;
  logic        s_cyc_i, s_stb_i, s_we_i, s_ack_o;
  logic [15:0] mem_adr_o, io_adr_o;
  logic [7:0]  mem_dat_o, mem_dat_i, io_dat_o, io_dat_i;
  logic        mem_cyc_o, mem_stb_o, mem_we_o, mem_ack_i;
  logic        io_cyc_o, io_stb_o, io_we_o, io_ack_i;
  logic        tmo_o;
  logic [7:0]  tmo_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;
  logic [7:0] exp_q[$];

  wb_cpu_bus_decoder #(.TIMEOUT_CYCLES(TMO), .FLOAT_DATA(FLOAT)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .s_adr_i(s_adr_i), .s_tga_i(s_tga_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_ack_o(s_ack_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_ack_i(mem_ack_i),
    .io_adr_o(io_adr_o), .io_dat_o(io_dat_o), .io_dat_i(io_dat_i),
    .io_cyc_o(io_cyc_o), .io_stb_o(io_stb_o), .io_we_o(io_we_o),
    .io_ack_i(io_ack_i),
    .tmo_o(tmo_o), .tmo_cnt_o(tmo_cnt_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    s_cyc_i   = 1'b0;
    s_stb_i   = 1'b0;
    s_we_i    = 1'b0;
    s_tga_i   = 2'b00;
    s_adr_i   = '0;
    s_dat_i   = '0;
    mem_ack_i = 1'b0;
    io_ack_i  = 1'b0;
    mem_dat_i = '0;
    io_dat_i  = '0;
  endtask

  // One master cycle. The slave acks on stb cycle w+1 (w = wait states);
  // w >= TMO means it never acks. Called and returns on a negative edge.
  task automatic run_txn(input logic [1:0] tga, input logic [15:0] adr,
                         input logic [7:0] dat, input logic we, input int w,
                         input int hold, input logic [7:0] sdat);
    logic [7:0] exp_data, got_data;
    int exp_lat, exp_stb, exp_tmo, lat;
    int mem_n, io_n, tmo_n, bad_port, bad_hold;
    mem_n = 0; io_n = 0; tmo_n = 0; bad_port = 0; bad_hold = 0;
    lat = 0; got_data = '0;
    // Reference model at transaction level.
    if (tga[1]) begin
      exp_data = FLOAT; exp_lat = 2; exp_stb = 0; exp_tmo = 0;
    end else if (w < TMO) begin
      exp_data = sdat; exp_lat = w + 3; exp_stb = w + 1; exp_tmo = 0;
    end else begin
      exp_data = FLOAT; exp_lat = TMO + 2; exp_stb = TMO; exp_tmo = 1;
      if (model_cnt < 255) model_cnt++;
    end
    exp_q.push_back(exp_data);

    s_tga_i = tga; s_adr_i = adr; s_dat_i = dat; s_we_i = we;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (mem_stb_o && io_stb_o) bad_port++;
      if ((tga == 2'b00 && io_stb_o) || (tga == 2'b01 && mem_stb_o) ||
          (tga[1] && (mem_stb_o || io_stb_o))) bad_port++;
      if (mem_cyc_o !== mem_stb_o || io_cyc_o !== io_stb_o) bad_hold++;
      if (!mem_stb_o && mem_we_o) bad_hold++;
      if (!io_stb_o && io_we_o) bad_hold++;
      if (mem_stb_o) begin
        mem_n++;
        if (mem_adr_o !== adr || mem_dat_o !== dat || mem_we_o !== we) bad_hold++;
      end
      if (io_stb_o) begin
        io_n++;
        if (io_adr_o !== adr || io_dat_o !== dat || io_we_o !== we) bad_hold++;
      end
      if (tmo_o) tmo_n++;
      mem_ack_i = mem_stb_o && (mem_n == w + 1);
      io_ack_i  = io_stb_o && (io_n == w + 1);
      mem_dat_i = mem_ack_i ? sdat : ~sdat;
      io_dat_i  = io_ack_i ? sdat : ~sdat;
      if (s_ack_o) begin
        lat = n;
        got_data = s_dat_o;
        break;
      end
    end
    mem_ack_i = 1'b0;
    io_ack_i  = 1'b0;
    check_eq("ack_latency", lat, exp_lat);
    check_eq("rdata", got_data, exp_q.pop_front());
    check_eq("stb_cycles", mem_n + io_n, exp_stb);
    check_eq("tmo_pulses", tmo_n, exp_tmo);
    check_eq("tmo_cnt", tmo_cnt_o, model_cnt);
    check_eq("port_select", bad_port, 0);
    check_eq("slave_hold", bad_hold, 0);
    // Keep the strobe up a while: no new cycle and no repeat ack may start.
    bad_port = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (s_ack_o || mem_stb_o || io_stb_o) bad_port++;
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    if (s_ack_o || mem_stb_o || io_stb_o) bad_port++;
    check_eq("release_quiet", bad_port, 0);
    check_eq("sdat_hold", s_dat_o, exp_data);
  endtask

  initial begin
    int bad;
    idle_inputs();
    nrst_i = 1'b0;
    #12;
    check_eq("reset_outs", {s_dat_o, s_ack_o, mem_adr_o, mem_dat_o, mem_cyc_o,
                            mem_stb_o, mem_we_o, io_adr_o[15:8]} , 32'h0);
    check_eq("reset_outs2", {io_adr_o[7:0], io_dat_o, io_cyc_o, io_stb_o, io_we_o,
                             tmo_o, tmo_cnt_o}, 32'h0);
    @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);

    // Directed scenarios.
    run_txn(2'b00, 16'h4000, 8'h00, 1'b0, 0, 0, 8'hA5);      // zero-wait mem read
    run_txn(2'b01, 16'h7F10, 8'h8C, 1'b1, 3, 1, 8'h00);      // io write, 3 waits
    run_txn(2'b00, 16'h1234, 8'h00, 1'b0, NEVER, 0, 8'h55);  // timeout
    // Late ack from the memory after the timeout must be ignored.
    bad = 0;
    mem_ack_i = 1'b1; mem_dat_i = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (s_ack_o || tmo_o || mem_stb_o) bad++;
    end
    mem_ack_i = 1'b0;
    check_eq("late_ack_ignored", bad, 0);
    check_eq("late_ack_cnt", tmo_cnt_o, model_cnt);
    check_eq("late_ack_sdat", s_dat_o, FLOAT);
    run_txn(2'b10, 16'h0042, 8'h00, 1'b0, 0, 0, 8'h00);      // unmapped tag
    run_txn(2'b11, 16'hBEEF, 8'h77, 1'b1, 0, 2, 8'h00);      // unmapped write
    run_txn(2'b00, 16'h2222, 8'h00, 1'b0, TMO - 1, 0, 8'h3C); // ack on last cycle

    // Master abort at the second stb cycle.
    bad = 0;
    s_tga_i = 2'b00; s_adr_i = 16'h5555; s_dat_i = 8'h00; s_we_i = 1'b0;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check_eq("abort_stb_before", mem_stb_o, 1'b1);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("abort_stb_drop", {mem_cyc_o, mem_stb_o, mem_we_o}, 3'b000);
    for (int i = 0; i < 20; i++) begin
      if (s_ack_o || tmo_o || mem_stb_o) bad++;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check_eq("abort_quiet", bad, 0);

    // Asynchronous reset in the middle of an io cycle.
    s_tga_i = 2'b01; s_adr_i = 16'h0F0F; s_dat_i = 8'h5A; s_we_i = 1'b1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check_eq("pre_reset_io", io_stb_o, 1'b1);
    #2;
    nrst_i = 1'b0;
    #1;
    check_eq("async_reset_outs",
             32'(|{s_dat_o, s_ack_o, mem_adr_o, mem_dat_o, mem_cyc_o, mem_stb_o,
                   mem_we_o, io_adr_o, io_dat_o, io_cyc_o, io_stb_o, io_we_o,
                   tmo_o, tmo_cnt_o}), 0);
    idle_inputs();
    model_cnt = 0;
    @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);
    run_txn(2'b00, 16'h4000, 8'h00, 1'b0, 1, 0, 8'hC3);

    // Random transactions.
    for (int t = 0; t < 40; t++) begin
      int w;
      w = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, TMO - 1));
      run_txn(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), w, int'($urandom_range(0, 2)),
              8'($urandom));
    end

    // Drive the watchdog counter into saturation.
    while (model_cnt < 255) begin
      run_txn(2'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 1'b0,
              NEVER, 0, 8'($urandom));
    end
    run_txn(2'b01, 16'h0001, 8'h00, 1'b0, NEVER, 0, 8'h00);
    check_eq("tmo_cnt_saturated", tmo_cnt_o, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so a stuck design still ends the run.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
